// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use stall, mul/div freeze and branch flush control
module hazard_stall_unit #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_ID_Rs,
   input  logic [4:0]       IF_ID_Rt,
   input  logic             IF_ID_UsesRt,
   input  logic [4:0]       ID_EX_Rt,
   input  logic             ID_EX_MemRead,
   input  logic             ID_EX_MulDiv,
   input  logic             EX_BranchTaken,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             ID_EX_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic             EX_MEM_Bubble,
   output logic             MD_Start,
   output logic             MD_Busy,
   output logic [CNT_W-1:0] StallCycles,
   output logic [7:0]       FlushCount
);

   typedef enum logic {RUN, MD_BUSY} state_t;

   // Entry cycle plus the busy cycles before release add up to MD_LATENCY-1 freeze cycles.
   localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 2);

   state_t     state, state_nxt;
   logic [7:0] md_cnt, md_cnt_nxt;
   logic       load_use;
   logic       flush_evt;

   // Load in EX writes a register the instruction in ID reads; $0 is never a real dependency.
   always_comb begin
      load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                 ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
   end

   // Next-state and control outputs; reset forces the free-running default pattern.
   always_comb begin
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      ID_EX_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Bubble  = 1'b0;
      EX_MEM_Bubble = 1'b0;
      MD_Start      = 1'b0;
      MD_Busy       = 1'b0;
      flush_evt     = 1'b0;
      state_nxt     = state;
      md_cnt_nxt    = md_cnt;
      if (rst_n) begin
         case (state)
            RUN: begin
               if (EX_BranchTaken) begin
                  IF_ID_Flush  = 1'b1;
                  ID_EX_Bubble = 1'b1;
                  flush_evt    = 1'b1;
               end else if (ID_EX_MulDiv) begin
                  PCWrite       = 1'b0;
                  IF_ID_Write   = 1'b0;
                  ID_EX_Write   = 1'b0;
                  EX_MEM_Bubble = 1'b1;
                  MD_Start      = 1'b1;
                  md_cnt_nxt    = MD_LOAD;
                  state_nxt     = MD_BUSY;
               end else if (load_use) begin
                  PCWrite      = 1'b0;
                  IF_ID_Write  = 1'b0;
                  ID_EX_Bubble = 1'b1;
               end
            end
            MD_BUSY: begin
               MD_Busy = 1'b1;
               if (md_cnt != 8'd0) begin
                  PCWrite       = 1'b0;
                  IF_ID_Write   = 1'b0;
                  ID_EX_Write   = 1'b0;
                  EX_MEM_Bubble = 1'b1;
                  md_cnt_nxt    = md_cnt - 8'd1;
               end else begin
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // State register and mul/div down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         md_cnt <= 8'd0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // Saturating performance counters for stall cycles and taken-branch flushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCycles <= '0;
         FlushCount  <= 8'd0;
      end else begin
         if (!PCWrite && (StallCycles != {CNT_W{1'b1}}))
            StallCycles <= StallCycles + CNT_W'(1);
         if (flush_evt && (FlushCount != 8'hFF))
            FlushCount <= FlushCount + 8'd1;
      end
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall and flush controller for the five-stage pipeline; complements the forwarding unit by handling hazards that bypassing cannot cover.
- Detects load-use hazards and inserts a single bubble.
- Freezes the front end while a multi-cycle multiply/divide occupies EX.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- MD_LATENCY, 4: total EX-stage cycles a mul/div occupies. Legal range 2..255.
- CNT_W, 16: width of StallCycles.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- IF_ID_Rs  in  5  source register rs of the instruction in ID.
- IF_ID_Rt  in  5  source register rt of the instruction in ID.
- IF_ID_UsesRt  in  1  instruction in ID reads rt as a source (not only as a destination).
- ID_EX_Rt  in  5  destination of the load in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_MulDiv  in  1  instruction in EX is mult/div.
- EX_BranchTaken  in  1  branch or jump in EX resolved as taken.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Write  out  1  ID/EX register enable.
- IF_ID_Flush  out  1  clear IF/ID to a NOP.
- ID_EX_Bubble  out  1  load a NOP into ID/EX.
- EX_MEM_Bubble  out  1  load a NOP into EX/MEM.
- MD_Start  out  1  one-cycle start pulse to the mul/div unit.
- MD_Busy  out  1  FSM is in MD_BUSY.
- StallCycles  out  CNT_W  count of cycles with PCWrite=0; saturates at all-ones.
- FlushCount  out  8  count of taken-branch flushes; saturates at 255.

Behaviour:
- Default (RUN, no event): PCWrite=IF_ID_Write=ID_EX_Write=1; all other control outputs 0.
- Control outputs are combinational from FSM state plus current inputs. Counters and state are registered on the rising edge of clk.
- Reset: while rst_n=0, state=RUN, internal down-counter=0, StallCycles=0, FlushCount=0.
  - During reset, control outputs are forced to the default values regardless of inputs.
  - Reset asserted mid-MD_BUSY abandons the operation; no MD_Start is issued on exit from reset.
- FSM states: RUN, MD_BUSY. In RUN, events are evaluated in priority order; only the first match acts:
  1. Flush, when EX_BranchTaken=1: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1. FlushCount increments. State stays RUN.
  2. Mul/div entry, when ID_EX_MulDiv=1:
     - PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1, MD_Start=1.
     - Counter loads MD_LATENCY-2; next state MD_BUSY.
  3. Load-use, when ID_EX_MemRead=1 and ID_EX_Rt!=0 and (ID_EX_Rt==IF_ID_Rs, or IF_ID_UsesRt=1 and ID_EX_Rt==IF_ID_Rt):
     - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, for exactly one cycle.
     - The inserted bubble clears ID_EX_MemRead in the next cycle, so the stall self-terminates.
- MD_BUSY:
  - While counter!=0: same freeze pattern as mul/div entry but MD_Start=0, MD_Busy=1; counter decrements each cycle.
  - When counter==0 (release cycle): default outputs with MD_Busy=1; next state RUN.
  - All of ID_EX_MulDiv, ID_EX_MemRead, EX_BranchTaken and the register fields are ignored in MD_BUSY.
- Mul/div latency: EX occupancy is exactly MD_LATENCY cycles. Front-end freeze is MD_LATENCY-1 cycles, counted from the entry cycle through the last non-release cycle.
  - MD_LATENCY=2: the entry cycle is followed immediately by the release cycle.
- Register $0 never causes a load-use stall.
- A load whose Rt matches both Rs and Rt still produces a single one-cycle stall.
- Flush takes precedence over any coincident load-use or mul/div input in the same cycle; no stall is asserted that cycle.
- StallCycles increments every cycle in which PCWrite=0. It holds at 2^CNT_W-1 once reached.
- FlushCount holds at 255 once reached.

Test Plan:
1. Load-use on rs: ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 for one cycle, then MemRead=0 → PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly 1 cycle; StallCycles=1.
2. No false stall: (a) ID_EX_Rt=0 with IF_ID_Rs=0; (b) ID_EX_Rt=7, IF_ID_Rt=7, IF_ID_UsesRt=0 → default outputs in both cases, StallCycles=0.
3. Mul/div, MD_LATENCY=4: ID_EX_MulDiv=1 held → MD_Start on cycle 0 only; PCWrite=0 on cycles 0–2; release on cycle 3; MD_Busy=1 on cycles 1–3; StallCycles=3. Repeat with MD_LATENCY=2 → exactly 1 freeze cycle.
4. Branch priority: EX_BranchTaken=1, ID_EX_MulDiv=1, and a load-use match in the same cycle → IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, MD_Start=0; state stays RUN; FlushCount=1.
5. Reset mid-operation: drop rst_n asynchronously on the second MD_BUSY cycle → outputs immediately default, MD_Busy=0, counters 0. After release with inputs idle → no MD_Start.
6. Saturation: CNT_W=4, sustain 20 load-use cycles → StallCycles=15. Apply 300 flushes → FlushCount=255.
